qtr_scan_sequencer: RTL and testbench



---
 rtl/qtr_scan_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_qtr_scan_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qtr_scan_sequencer.sv
// -----------------------------------------------------------------------------
// qtr_scan_sequencer
//
// Scan sequencer for the 8-channel QTR reflectance line sensor. Every
// PERIOD_CYC cycles (while en=1) it pulses stp to start an RC read. It then
// waits SETTLE_CYC cycles and captures the weighted sum SP and the active
// sensor count SN. It divides SP by SN with a serial restoring divider, one
// quotient bit per cycle, and publishes the line position with a one-cycle
// pos_valid strobe. When SN=0 the line is lost. In that case the position is
// pinned to the side where the line was last seen: 0 or EDGE_HI.
//
// Optional build macro:
//   QTR_SEQ_ROUND_EN  defined   -> quotient rounded to nearest, saturating at 255
//                     undefined -> truncating quotient, no rounding logic
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst        synchronous active-low reset
//   en         enable periodic scanning
//   stp        one-cycle trigger to the QTR read datapath
//   sp_in      weighted sum from the position datapath (sampled in CAPT only)
//   sn_in      active sensor count from the position datapath (sampled in CAPT only)
//   pos        line position, 0..EDGE_HI, updated only when pos_valid=1
//   pos_valid  one-cycle strobe, pos/line_lost updated
//   line_lost  last scan saw SN=0
//   busy       a scan is in progress (state != IDLE)
//   overrun    sticky: a period tick arrived while a scan was still running
// -----------------------------------------------------------------------------
module qtr_scan_sequencer #(
  parameter int PERIOD_CYC = 50000,
  parameter int SETTLE_CYC = 2000,
  parameter int MID_POS    = 45,
  parameter int EDGE_HI    = 90
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        stp,
  input  logic [15:0] sp_in,
  input  logic [4:0]  sn_in,
  output logic [7:0]  pos,
  output logic        pos_valid,
  output logic        line_lost,
  output logic        busy,
  output logic        overrun
);

  localparam int CNT_W = $clog2(PERIOD_CYC);
  localparam int SET_W = $clog2(SETTLE_CYC) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT,
    S_CAPT,
    S_DIV,
    S_LOST,
    S_DONE
  } state_e;

  state_e             state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [3:0]         bit_q,    bit_d;
  logic [15:0]        quo_q,    quo_d;   // dividend shifts out, quotient shifts in
  logic [15:0]        rem_q,    rem_d;
  logic [15:0]        dvs_q,    dvs_d;
  logic [7:0]         pos_q,    pos_d;
  logic               lost_q,   lost_d;
  logic               ovr_q,    ovr_d;

  logic        tick;
  logic [15:0] rem_sh;
  logic        rem_ge;
  logic [15:0] rem_nx;
  logic [15:0] quo_nx;
  logic [7:0]  div_result;

  assign tick = en && (cnt_q == '0);

  // One restoring-division step. The shifted partial remainder is 17 bits
  // wide. Its top bit is rem_q[15], and when that bit is set the value
  // already exceeds any 16-bit divisor. The 16-bit modular subtract still
  // yields the exact remainder, because the true result is below the divisor.
  always_comb begin
    rem_sh = {rem_q[14:0], quo_q[15]};
    rem_ge = rem_q[15] || (rem_sh >= dvs_q);
    rem_nx = rem_ge ? (rem_sh - dvs_q) : rem_sh;
    quo_nx = {quo_q[14:0], rem_ge};
  end

`ifdef QTR_SEQ_ROUND_EN
  // Round to nearest: bump when 2*remainder >= divisor, saturate at 255.
  logic       round_up;
  logic [8:0] rnd_sum;

  always_comb begin
    round_up = rem_nx[15] || ({rem_nx[14:0], 1'b0} >= dvs_q);
    rnd_sum  = {1'b0, quo_nx[7:0]} + {8'd0, round_up};
    if ((quo_nx[15:8] != 8'd0) || rnd_sum[8]) begin
      div_result = 8'hFF;
    end else begin
      div_result = rnd_sum[7:0];
    end
  end
`else
  assign div_result = quo_nx[7:0];
`endif

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    bit_d    = bit_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    pos_d    = pos_q;
    lost_d   = lost_q;
    ovr_d    = ovr_q;

    // Period counter free-runs while enabled and parks at 0 otherwise, so a
    // rising en produces an immediate tick.
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(PERIOD_CYC - 1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // A tick that lands on any non-idle cycle, DONE included, is dropped.
    if (tick && (state_q != S_IDLE)) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_d = S_TRIG;
        end
      end
      S_TRIG: begin
        settle_d = SET_W'(SETTLE_CYC - 1);
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (settle_q == '0) begin
          state_d = S_CAPT;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      S_CAPT: begin
        quo_d = sp_in;
        dvs_d = {11'd0, sn_in};
        rem_d = '0;
        bit_d = 4'd15;
        state_d = (sn_in == 5'd0) ? S_LOST : S_DIV;
      end
      S_DIV: begin
        quo_d = quo_nx;
        rem_d = rem_nx;
        bit_d = bit_q - 4'd1;
        if (bit_q == 4'd0) begin
          // Results are registered on entry to DONE, so they are visible
          // in the same cycle as pos_valid.
          pos_d   = div_result;
          lost_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      S_LOST: begin
        // Pin to the side the line was last seen on; the midpoint goes high.
        lost_d  = 1'b1;
        pos_d   = (pos_q < 8'(MID_POS)) ? 8'd0 : 8'(EDGE_HI);
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments only, and the
  // synchronous reset is sampled inside the clocked block like any other input.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      settle_q <= '0;
      bit_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      pos_q    <= 8'(MID_POS);
      lost_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      bit_q    <= bit_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      pos_q    <= pos_d;
      lost_q   <= lost_d;
      ovr_q    <= ovr_d;
    end
  end

  assign stp       = (state_q == S_TRIG);
  assign pos_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign pos       = pos_q;
  assign line_lost = lost_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_qtr_scan_sequencer.sv
module tb_qtr_scan_sequencer;

  localparam int P_A   = 30;
  localparam int S_A   = 4;
  localparam int P_B   = 10;
  localparam int S_B   = 20;
  localparam int MID   = 45;
  localparam int EDGE  = 90;
  localparam int NEVER = 32'h7fff_ffff;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: normal period, checked cycle by cycle against the model.
  logic        rst_a = 1'b0;
  logic        en_a  = 1'b0;
  logic [15:0] sp_a  = 16'd10;
  logic [4:0]  sn_a  = 5'd1;
  logic        stp_a, pos_valid_a, line_lost_a, busy_a, overrun_a;
  logic [7:0]  pos_a;

  // DUT B: period shorter than a scan, used for the overrun scenario.
  logic        rst_b = 1'b0;
  logic        en_b  = 1'b0;
  logic [15:0] sp_b  = 16'd90;
  logic [4:0]  sn_b  = 5'd2;
  logic        stp_b, pos_valid_b, line_lost_b, busy_b, overrun_b;
  logic [7:0]  pos_b;

  qtr_scan_sequencer #(.PERIOD_CYC(P_A), .SETTLE_CYC(S_A), .MID_POS(MID), .EDGE_HI(EDGE)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .stp(stp_a), .sp_in(sp_a), .sn_in(sn_a),
    .pos(pos_a), .pos_valid(pos_valid_a), .line_lost(line_lost_a), .busy(busy_a), .overrun(overrun_a)
  );

  qtr_scan_sequencer #(.PERIOD_CYC(P_B), .SETTLE_CYC(S_B), .MID_POS(MID), .EDGE_HI(EDGE)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .stp(stp_b), .sp_in(sp_b), .sn_in(sn_b),
    .pos(pos_b), .pos_valid(pos_valid_b), .line_lost(line_lost_b), .busy(busy_b), .overrun(overrun_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model of DUT A. A scan is described by absolute cycle numbers:
  // the stp cycle, the capture cycle, and the cycle in which the result
  // appears. The position comes straight from integer division.
  // ---------------------------------------------------------------------------
  int cyc     = 0;
  int m_cnt   = 0;
  int stp_at  = NEVER;
  int cap_at  = NEVER;
  int done_at = NEVER;
  int pend_pos = MID;
  int m_pos    = MID;
  bit pend_lost = 1'b0;
  bit m_lost    = 1'b0;
  bit m_ovr     = 1'b0;
  bit active    = 1'b0;
  bit e_stp = 1'b0, e_busy = 1'b0, e_valid = 1'b0;

  always @(posedge clk) begin : model
    int cur;
    int q;
    int r;
    bit tick;
    bit was_busy;
    cur = cyc;
    if (!rst_a) begin
      active = 1'b0;
      m_cnt  = 0;
      m_pos  = MID;
      m_lost = 1'b0;
      m_ovr  = 1'b0;
    end else begin
      was_busy = active;
      tick = en_a && (m_cnt == 0);
      if (active && cur == cap_at) begin
        if (sn_a == 0) begin
          done_at   = cur + 2;
          pend_lost = 1'b1;
          pend_pos  = (m_pos < MID) ? 0 : EDGE;
        end else begin
          q = int'(sp_a) / int'(sn_a);
          r = int'(sp_a) % int'(sn_a);
`ifdef QTR_SEQ_ROUND_EN
          if (2 * r >= int'(sn_a)) q = q + 1;
          if (q > 255) q = 255;
`endif
          done_at   = cur + 17;
          pend_lost = 1'b0;
          pend_pos  = q % 256;
        end
      end
      if (active && cur == done_at) active = 1'b0;
      if (tick) begin
        if (was_busy) begin
          m_ovr = 1'b1;
        end else begin
          active  = 1'b1;
          stp_at  = cur + 1;
          cap_at  = cur + 2 + S_A;
          done_at = NEVER;
        end
      end
      m_cnt = en_a ? (m_cnt + 1) % P_A : 0;
      if (active && (cur + 1) == done_at) begin
        m_pos  = pend_pos;
        m_lost = pend_lost;
      end
    end
    cyc     = cur + 1;
    e_stp   = active && (cyc == stp_at);
    e_busy  = active;
    e_valid = active && (cyc == done_at);
  end

  // Single compare process for DUT A, every cycle after the first edge.
  always @(negedge clk) begin
    if (cyc > 0) begin
      check("a_stp",       stp_a,       e_stp);
      check("a_busy",      busy_a,      e_busy);
      check("a_pos_valid", pos_valid_a, e_valid);
      check("a_pos",       pos_a,       m_pos);
      check("a_line_lost", line_lost_a, m_lost);
      check("a_overrun",   overrun_a,   m_ovr);
    end
  end

  // Directed scan on DUT A with hand-computed literal expectations.
  task automatic scan(input int sp, input int sn, input int exp_pos, input bit exp_lost, input string name);
    int t;
    @(negedge clk);
    #1;
    sp_a = 16'(sp);
    sn_a = 5'(sn);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (stp_a !== 1'b1 && t < 200);
    if (t >= 200) begin
      check({name, "_stp_timeout"}, 0, 1);
      return;
    end
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (pos_valid_a !== 1'b1 && t < 200);
    check({name, "_latency"}, t, 1 + S_A + 1 + ((sn == 0) ? 1 : 16));
    check({name, "_pos"}, pos_a, exp_pos);
    check({name, "_lost"}, line_lost_a, exp_lost);
    @(negedge clk);
    check({name, "_busy_after"}, busy_a, 0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t;
    int n_stp;
    int n_valid;
    int since_stp;
    bit in_scan;
    bit ovr_seen;

    repeat (3) @(negedge clk);
    check("rst_pos",     pos_a,       MID);
    check("rst_busy",    busy_a,      0);
    check("rst_overrun", overrun_a,   0);
    check("rst_valid",   pos_valid_a, 0);
    #1;
    rst_a = 1'b1;
    en_a  = 1'b1;

    scan(90, 2, 45, 1'b0, "t1");
    scan(30, 1, 30, 1'b0, "t2");
    scan(360, 8, 45, 1'b0, "t3");
    scan(80, 1, 80, 1'b0, "t4");
    scan(20, 1, 20, 1'b0, "pre_low");
    scan(50, 0, 0, 1'b1, "lost_low");
    scan(70, 1, 70, 1'b0, "pre_high");
    scan(50, 0, 90, 1'b1, "lost_high");
    scan(45, 1, 45, 1'b0, "pre_mid");
    scan(50, 0, 90, 1'b1, "lost_mid");
`ifdef QTR_SEQ_ROUND_EN
    scan(110, 3, 37, 1'b0, "round_110");
`else
    scan(110, 3, 36, 1'b0, "trunc_110");
`endif
    scan(100, 3, 33, 1'b0, "div_100");

    // en falls mid-scan: the current scan completes, then no new trigger.
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (stp_a !== 1'b1 && t < 200);
    check("enfall_stp_seen", stp_a, 1);
    repeat (3) @(negedge clk);
    #1 en_a = 1'b0;
    n_stp = 0;
    n_valid = 0;
    repeat (80) begin
      @(negedge clk);
      if (stp_a === 1'b1) n_stp++;
      if (pos_valid_a === 1'b1) n_valid++;
    end
    check("enfall_no_stp", n_stp, 0);
    check("enfall_one_valid", n_valid, 1);

    // en rises: immediate tick, stp on the very next cycle.
    #1 en_a = 1'b1;
    @(negedge clk);
    check("enrise_stp", stp_a, 1);

    // Reset in the 5th DIV cycle, with a lost result latched beforehand.
    scan(80, 1, 80, 1'b0, "pre_rst");
    scan(50, 0, 90, 1'b1, "lost_pre_rst");
    @(negedge clk);
    #1;
    sp_a = 16'd80;
    sn_a = 5'd1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (stp_a !== 1'b1 && t < 200);
    check("rstdiv_stp_seen", stp_a, 1);
    repeat (10) @(negedge clk);
    #1 rst_a = 1'b0;
    @(negedge clk);
    check("rstdiv_pos",   pos_a,       MID);
    check("rstdiv_lost",  line_lost_a, 0);
    check("rstdiv_busy",  busy_a,      0);
    check("rstdiv_valid", pos_valid_a, 0);
    check("rstdiv_stp",   stp_a,       0);
    #1 rst_a = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (stp_a !== 1'b1 && t < 2);
    check("rstdiv_fresh_stp", stp_a, 1);

    // Randomized phase: inputs churn every cycle, en occasionally toggles.
    repeat (1500) begin
      @(negedge clk);
      #1;
      sp_a = 16'(10 + $urandom_range(0, 350));
      sn_a = 5'($urandom_range(0, 8));
      if ($urandom_range(0, 199) == 0) en_a = ~en_a;
    end
    en_a = 1'b1;

    // Overrun scenario on DUT B.
    @(negedge clk);
    check("b_rst_overrun", overrun_b, 0);
    #1;
    rst_b = 1'b1;
    en_b  = 1'b1;
    n_stp = 0;
    n_valid = 0;
    since_stp = 0;
    in_scan = 1'b0;
    ovr_seen = 1'b0;
    repeat (300) begin
      @(negedge clk);
      since_stp++;
      if (ovr_seen) check("b_ovr_sticky", overrun_b, 1);
      if (overrun_b === 1'b1) ovr_seen = 1'b1;
      if (stp_b === 1'b1) begin
        check("b_stp_while_busy", in_scan, 0);
        in_scan = 1'b1;
        since_stp = 0;
        n_stp++;
      end
      if (pos_valid_b === 1'b1) begin
        check("b_latency", since_stp, 1 + S_B + 1 + 16);
        check("b_pos", pos_b, 45);
        check("b_ovr_by_done", overrun_b, 1);
        in_scan = 1'b0;
        n_valid++;
      end
    end
    check("b_scans_ran", (n_stp >= 3) ? 1 : 0, 1);
    check("b_stp_vs_done", ((n_stp - n_valid) <= 1) ? 1 : 0, 1);
    check("b_ovr_end", overrun_b, 1);
    #1 rst_b = 1'b0;
    @(negedge clk);
    check("b_ovr_cleared", overrun_b, 0);
    check("b_busy_cleared", busy_b, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
